// File: rtl/sw_debounce_keys.sv
// ---------------------------------------------------------------------------
// sw_debounce_keys
//
// Switch conditioning stage in front of the password-entry FSM. Each slide
// switch is synchronised through two flops and debounced by its own counter.
// The stage then emits a clean level and a one-cycle rising-edge pulse. A
// registered key event follows one cycle after any rising pulse: the lowest
// index that rose, plus a flag saying that more than one switch rose together.
//
// Parameters:
//   N_SW            - number of switches (key_idx is 4 bits, so N_SW <= 16)
//   DEBOUNCE_CYCLES - cycles s2 must differ from the clean level (>= 2)
//   CNT_W           - debounce counter width
//
// Ports:
//   clk       - single clock, rising edge
//   reset_n   - asynchronous, active-low reset
//   SW        - raw asynchronous switch levels
//   sw_clean  - debounced switch levels
//   sw_rise   - one-cycle pulse per switch on a debounced 0->1 transition
//   key_valid - one-cycle pulse, one cycle after any sw_rise bit
//   key_idx   - lowest index set in sw_rise (held while key_valid = 0)
//   key_multi - more than one sw_rise bit set (held while key_valid = 0)
// ---------------------------------------------------------------------------
module sw_debounce_keys #(
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_SW-1:0] SW,
    output logic [N_SW-1:0] sw_clean,
    output logic [N_SW-1:0] sw_rise,
    output logic            key_valid,
    output logic [3:0]      key_idx,
    output logic            key_multi
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Per-switch synchroniser, debounce counter and rising-edge pulse
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_sw
            logic             s1_reg;
            logic             s2_reg;
            logic             clean_reg;
            logic             rise_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1_reg    <= 1'b0;
                    s2_reg    <= 1'b0;
                    clean_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    s1_reg   <= SW[gi];
                    s2_reg   <= s1_reg;
                    rise_reg <= 1'b0;
                    if (s2_reg == clean_reg) begin
                        // Agreement with the stable level (including a bounce
                        // back) throws away any partial count.
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_TERM) begin
                        clean_reg <= s2_reg;
                        cnt_reg   <= '0;
                        // Pulse only when the accepted level is a 1.
                        rise_reg  <= s2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            assign sw_clean[gi] = clean_reg;
            assign sw_rise[gi]  = rise_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Key event stage
    // -----------------------------------------------------------------------
    logic [3:0] lowest_idx;
    logic       multi_hit;

    always_comb begin
        lowest_idx = 4'd0;
        // Scan from the top so the lowest set bit wins.
        for (int i = N_SW - 1; i >= 0; i--) begin
            if (sw_rise[i]) begin
                lowest_idx = 4'(i);
            end
        end
        // x & (x-1) clears the lowest set bit; anything left means >1 set.
        multi_hit = |(sw_rise & (sw_rise - N_SW'(1)));
    end

    logic       key_valid_reg;
    logic [3:0] key_idx_reg;
    logic       key_multi_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_valid_reg <= 1'b0;
            key_idx_reg   <= 4'd0;
            key_multi_reg <= 1'b0;
        end else begin
            key_valid_reg <= |sw_rise;
            if (|sw_rise) begin
                key_idx_reg   <= lowest_idx;
                key_multi_reg <= multi_hit;
            end
        end
    end

    assign key_valid = key_valid_reg;
    assign key_idx   = key_idx_reg;
    assign key_multi = key_multi_reg;

endmodule
